// File: rtl/ex_mem_flag_stage_if.sv
// ex_mem_flag_stage_if: EX-side inputs and MEM/branch outputs of the EX/MEM flag stage
interface ex_mem_flag_stage_if #(
   parameter int DW = 16,
   parameter int RW = 4
);
   logic [DW-1:0] alu_out;
   logic [2:0]    alu_flags;
   logic [2:0]    alu_op;
   logic          ex_valid;
   logic          ex_flag_en;
   logic          ex_reg_we;
   logic [RW-1:0] ex_rd;
   logic          ex_is_branch;
   logic [2:0]    ex_cond;
   logic [DW-1:0] ex_target;
   logic          stall;
   logic          flush;
   logic          mem_valid;
   logic [DW-1:0] mem_result;
   logic [RW-1:0] mem_rd;
   logic          mem_reg_we;
   logic [2:0]    flags_q;
   logic          branch_taken;
   logic [DW-1:0] branch_pc;
   modport master (
      output alu_out, alu_flags, alu_op, ex_valid, ex_flag_en, ex_reg_we, ex_rd,
             ex_is_branch, ex_cond, ex_target, stall, flush,
      input  mem_valid, mem_result, mem_rd, mem_reg_we, flags_q, branch_taken, branch_pc
   );
   modport slave (
      input  alu_out, alu_flags, alu_op, ex_valid, ex_flag_en, ex_reg_we, ex_rd,
             ex_is_branch, ex_cond, ex_target, stall, flush,
      output mem_valid, mem_result, mem_rd, mem_reg_we, flags_q, branch_taken, branch_pc
   );
endinterface

// File: rtl/ex_mem_flag_stage.sv
// ex_mem_flag_stage: EX/MEM register, Z/V/N flag register and branch resolve; OVFL_CNT_EN adds an overflow counter
module ex_mem_flag_stage #(
   parameter int DW = 16,
   parameter int RW = 4
) (
   input logic clk,
   input logic rst,
`ifdef OVFL_CNT_EN
   output logic [15:0] ovfl_count,
`endif
   ex_mem_flag_stage_if.slave bus
);
   logic acc;
   logic wr_all;
   logic wr_z;
   logic [7:0] cond_vec;
   logic z, v, n;
   assign acc = bus.ex_valid & ~bus.stall & ~bus.flush;
   assign wr_all = acc & bus.ex_flag_en & (bus.alu_op[2:1] == 2'b00);
   assign wr_z = acc & bus.ex_flag_en & (bus.alu_op == 3'b010 || bus.alu_op == 3'b100 ||
                                         bus.alu_op == 3'b101 || bus.alu_op == 3'b110);
   assign {z, v, n} = bus.flags_q;
   // condition table indexed by ex_cond: ALWAYS, OV, LE, GE, LT, GT, EQ, NE
   assign cond_vec = {1'b1, v, n | z, z | (~z & ~n), n, ~z & ~n, z, ~z};
   assign bus.branch_taken = acc & bus.ex_is_branch & cond_vec[bus.ex_cond];
   assign bus.branch_pc = bus.branch_taken ? bus.ex_target : {DW{1'b0}};
   // EX/MEM pipeline register: flush loads a bubble, stall holds everything
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.mem_valid  <= 1'b0;
         bus.mem_result <= {DW{1'b0}};
         bus.mem_rd     <= {RW{1'b0}};
         bus.mem_reg_we <= 1'b0;
      end else if (bus.flush) begin
         bus.mem_valid  <= 1'b0;
         bus.mem_reg_we <= 1'b0;
      end else if (!bus.stall) begin
         bus.mem_valid  <= bus.ex_valid;
         bus.mem_result <= bus.alu_out;
         bus.mem_rd     <= bus.ex_rd;
         bus.mem_reg_we <= bus.ex_reg_we & bus.ex_valid;
      end
   end
   // flag register: ADD/SUB write all flags, logic/shift ops write Z only
   always_ff @(posedge clk) begin
      if (rst)
         bus.flags_q <= 3'b000;
      else
         bus.flags_q <= {(wr_all | wr_z) ? bus.alu_flags[2] : z,
                         wr_all ? bus.alu_flags[1] : v,
                         wr_all ? bus.alu_flags[0] : n};
   end
`ifdef OVFL_CNT_EN
   // saturating count of accepted ADD/SUB flag writes that overflowed
   always_ff @(posedge clk) begin
      if (rst)
         ovfl_count <= 16'h0000;
      else if (wr_all & bus.alu_flags[1] & ~&ovfl_count)
         ovfl_count <= ovfl_count + 16'h0001;
   end
`endif
endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// tb_ex_mem_flag_stage: table-driven and directed checks of ex_mem_flag_stage
module tb_ex_mem_flag_stage;
   logic clk;
   logic rst;
   int n_cmp;
   int n_bad;
`ifdef OVFL_CNT_EN
   logic [15:0] ovfl_count;
`endif
   ex_mem_flag_stage_if #(.DW(16), .RW(4)) bus ();
   ex_mem_flag_stage #(.DW(16), .RW(4)) dut (
      .clk(clk),
      .rst(rst),
`ifdef OVFL_CNT_EN
      .ovfl_count(ovfl_count),
`endif
      .bus(bus.slave)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   typedef struct {
      logic v, fe, we, br, st, fl;
      logic [2:0] op, af, cd;
      logic [3:0] rd;
      logic [15:0] ao, tg;
      logic tk;
      logic [15:0] pc;
      logic mv;
      logic [15:0] mr;
      logic [3:0] mrd;
      logic mwe;
      logic [2:0] fq;
   } vec_t;
   vec_t tv[28];
   function automatic vec_t mk(logic v, logic fe, logic we, logic br, logic st, logic fl,
                               logic [2:0] op, logic [2:0] af, logic [2:0] cd, logic [3:0] rd,
                               logic [15:0] ao, logic [15:0] tg, logic tk, logic [15:0] pc,
                               logic mv, logic [15:0] mr, logic [3:0] mrd, logic mwe,
                               logic [2:0] fq);
      vec_t t;
      t.v = v; t.fe = fe; t.we = we; t.br = br; t.st = st; t.fl = fl;
      t.op = op; t.af = af; t.cd = cd; t.rd = rd; t.ao = ao; t.tg = tg;
      t.tk = tk; t.pc = pc; t.mv = mv; t.mr = mr; t.mrd = mrd; t.mwe = mwe; t.fq = fq;
      return t;
   endfunction
   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic apply(input vec_t t);
      bus.ex_valid = t.v; bus.ex_flag_en = t.fe; bus.ex_reg_we = t.we; bus.ex_is_branch = t.br;
      bus.stall = t.st; bus.flush = t.fl; bus.alu_op = t.op; bus.alu_flags = t.af;
      bus.ex_cond = t.cd; bus.ex_rd = t.rd; bus.alu_out = t.ao; bus.ex_target = t.tg;
   endtask
   task automatic idle();
      apply(mk(0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0, 16'h0, 0, 16'h0, 0, 16'h0, 4'd0, 0, 3'd0));
   endtask
   task automatic chk_mem(input string nm, input logic mv, input logic [15:0] mr,
                          input logic [3:0] mrd, input logic mwe, input logic [2:0] fq);
      chk({nm, ".mem_valid"}, {15'd0, bus.mem_valid}, {15'd0, mv});
      chk({nm, ".mem_result"}, bus.mem_result, mr);
      chk({nm, ".mem_rd"}, {12'd0, bus.mem_rd}, {12'd0, mrd});
      chk({nm, ".mem_reg_we"}, {15'd0, bus.mem_reg_we}, {15'd0, mwe});
      chk({nm, ".flags_q"}, {13'd0, bus.flags_q}, {13'd0, fq});
   endtask
   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [7:0] tk_a;
      logic [7:0] tk_b;
      n_cmp = 0;
      n_bad = 0;
      tk_a = 8'h95;
      tk_b = 8'hE9;
      tv[0] = mk(1, 1, 1, 0, 0, 0, 3'd0, 3'b100, 3'd0, 4'd3, 16'h0000, 16'h0, 0, 16'h0, 1, 16'h0000, 4'd3, 1, 3'b100);
      tv[1] = mk(1, 1, 1, 0, 0, 0, 3'd1, 3'b011, 3'd0, 4'd5, 16'h1234, 16'h0, 0, 16'h0, 1, 16'h1234, 4'd5, 1, 3'b011);
      tv[2] = mk(1, 1, 0, 0, 0, 0, 3'd2, 3'b100, 3'd0, 4'd6, 16'h00FF, 16'h0, 0, 16'h0, 1, 16'h00FF, 4'd6, 0, 3'b111);
      tv[3] = mk(1, 1, 1, 0, 0, 0, 3'd3, 3'b000, 3'd0, 4'd7, 16'hAAAA, 16'h0, 0, 16'h0, 1, 16'hAAAA, 4'd7, 1, 3'b111);
      tv[4] = mk(1, 1, 1, 0, 0, 0, 3'd4, 3'b000, 3'd0, 4'd1, 16'h0002, 16'h0, 0, 16'h0, 1, 16'h0002, 4'd1, 1, 3'b011);
      tv[5] = mk(1, 1, 1, 0, 0, 0, 3'd7, 3'b100, 3'd0, 4'd2, 16'h0003, 16'h0, 0, 16'h0, 1, 16'h0003, 4'd2, 1, 3'b011);
      tv[6] = mk(1, 0, 1, 0, 0, 0, 3'd0, 3'b100, 3'd0, 4'd4, 16'h0004, 16'h0, 0, 16'h0, 1, 16'h0004, 4'd4, 1, 3'b011);
      tv[7] = mk(0, 1, 1, 0, 0, 0, 3'd0, 3'b100, 3'd0, 4'd8, 16'h0005, 16'h0, 0, 16'h0, 0, 16'h0005, 4'd8, 0, 3'b011);
      tv[8] = mk(1, 1, 1, 0, 0, 0, 3'd0, 3'b000, 3'd0, 4'd9, 16'h0006, 16'h0, 0, 16'h0, 1, 16'h0006, 4'd9, 1, 3'b000);
      for (int c = 0; c < 8; c++) begin
         tv[9 + c] = mk(1, 0, 0, 1, 0, 0, 3'd0, 3'b000, 3'(c), 4'd0, 16'(16 + c), 16'h0040,
                        tk_a[c], tk_a[c] ? 16'h0040 : 16'h0000, 1, 16'(16 + c), 4'd0, 0, 3'b000);
         tv[18 + c] = mk(1, 0, 0, 1, 0, 0, 3'd0, 3'b000, 3'(c), 4'd0, 16'(32 + c), 16'h0040,
                         tk_b[c], tk_b[c] ? 16'h0040 : 16'h0000, 1, 16'(32 + c), 4'd0, 0, 3'b011);
      end
      tv[17] = mk(1, 1, 1, 0, 0, 0, 3'd1, 3'b011, 3'd0, 4'd2, 16'h0100, 16'h0, 0, 16'h0, 1, 16'h0100, 4'd2, 1, 3'b011);
      tv[26] = mk(1, 0, 0, 1, 1, 0, 3'd0, 3'b000, 3'd7, 4'd0, 16'h0099, 16'h0040, 0, 16'h0, 1, 16'h0027, 4'd0, 0, 3'b011);
      tv[27] = mk(1, 0, 0, 1, 0, 1, 3'd0, 3'b000, 3'd7, 4'd0, 16'h0099, 16'h0040, 0, 16'h0, 0, 16'h0027, 4'd0, 0, 3'b011);
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_mem("reset", 0, 16'h0, 4'd0, 0, 3'b000);
`ifdef OVFL_CNT_EN
      chk("reset.ovfl_count", ovfl_count, 16'h0000);
`endif
      for (int i = 0; i < 28; i++) begin
         apply(tv[i]);
         #2;
         chk($sformatf("v%0d.branch_taken", i), {15'd0, bus.branch_taken}, {15'd0, tv[i].tk});
         chk($sformatf("v%0d.branch_pc", i), bus.branch_pc, tv[i].pc);
         edge_step();
         chk_mem($sformatf("v%0d", i), tv[i].mv, tv[i].mr, tv[i].mrd, tv[i].mwe, tv[i].fq);
      end
      apply(mk(1, 1, 1, 0, 1, 0, 3'd0, 3'b100, 3'd0, 4'd10, 16'hBEEF, 16'h0, 0, 16'h0, 0, 16'h0, 4'd0, 0, 3'd0));
      for (int k = 0; k < 3; k++) begin
         edge_step();
         chk_mem($sformatf("stall%0d", k), 0, 16'h0027, 4'd0, 0, 3'b011);
      end
      bus.stall = 1'b0;
      edge_step();
      chk_mem("release", 1, 16'hBEEF, 4'd10, 1, 3'b100);
      apply(mk(1, 1, 1, 0, 1, 1, 3'd0, 3'b010, 3'd0, 4'd11, 16'hCAFE, 16'h0, 0, 16'h0, 0, 16'h0, 4'd0, 0, 3'd0));
      edge_step();
      chk_mem("stall_flush", 0, 16'hBEEF, 4'd10, 0, 3'b100);
      apply(mk(1, 1, 1, 0, 0, 0, 3'd0, 3'b111, 3'd0, 4'd12, 16'h5555, 16'h0, 0, 16'h0, 0, 16'h0, 4'd0, 0, 3'd0));
      edge_step();
      chk_mem("pre_rst", 1, 16'h5555, 4'd12, 1, 3'b111);
      rst = 1'b1;
      bus.stall = 1'b1;
      bus.flush = 1'b1;
      edge_step();
      rst = 1'b0;
      chk_mem("mid_rst", 0, 16'h0000, 4'd0, 0, 3'b000);
      idle();
`ifdef OVFL_CNT_EN
      apply(mk(1, 1, 1, 0, 0, 0, 3'd0, 3'b010, 3'd0, 4'd1, 16'h8000, 16'h0, 0, 16'h0, 0, 16'h0, 4'd0, 0, 3'd0));
      edge_step();
      bus.flush = 1'b1;
      edge_step();
      bus.flush = 1'b0;
      bus.alu_op = 3'd1;
      edge_step();
      chk("ovfl_two", ovfl_count, 16'h0002);
      bus.alu_op = 3'd0;
      repeat (65533) @(posedge clk);
      #1;
      chk("ovfl_full", ovfl_count, 16'hFFFF);
      edge_step();
      chk("ovfl_sat", ovfl_count, 16'hFFFF);
      idle();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule
